// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, overflow/underflow pulses and a build-time FWFT read option.
module sync_fifo_flags #(
  parameter int datawidth = 8,
  parameter int depth     = 8,
  parameter int af_thresh = depth - 2,
  parameter int ae_thresh = 2,
  parameter bit fwft      = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wen,
  input  logic                       ren,
  input  logic [datawidth-1:0]       din,
  output logic [datawidth-1:0]       dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(depth + 1);
  localparam int PW = $clog2(depth);
  localparam logic [PW-1:0] P_ONE   = PW'(1);
  localparam logic [PW-1:0] P_LAST  = PW'(depth - 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_DEPTH = CW'(depth);
  localparam logic [CW-1:0] C_AF    = CW'(af_thresh);
  localparam logic [CW-1:0] C_AE    = CW'(ae_thresh);

  logic [datawidth-1:0] r_mem [depth];
  logic [datawidth-1:0] r_dout;
  logic [PW-1:0]        r_rd_ptr;
  logic [PW-1:0]        r_wr_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_full;
  logic                 r_empty;
  logic                 r_af;
  logic                 r_ae;
  logic                 r_ovf;
  logic                 r_udf;

  logic                 w_rd_acc;
  logic                 w_wr_acc;
  logic [PW-1:0]        w_rd_ptr_next;
  logic [PW-1:0]        w_wr_ptr_next;
  logic [CW-1:0]        w_count_next;

  // A full FIFO still takes a write when the same-cycle read frees a slot.
  assign w_rd_acc = !rst && ren && !r_empty;
  assign w_wr_acc = !rst && wen && (!r_full || w_rd_acc);

  // Next-state pointers (explicit wrap so any depth works) and occupancy
  always_comb begin
    w_rd_ptr_next = r_rd_ptr;
    w_wr_ptr_next = r_wr_ptr;
    w_count_next  = r_count;
    if (w_rd_acc) begin
      if (r_rd_ptr == P_LAST) begin
        w_rd_ptr_next = {PW{1'b0}};
      end else begin
        w_rd_ptr_next = r_rd_ptr + P_ONE;
      end
    end else begin
      w_rd_ptr_next = r_rd_ptr;
    end
    if (w_wr_acc) begin
      if (r_wr_ptr == P_LAST) begin
        w_wr_ptr_next = {PW{1'b0}};
      end else begin
        w_wr_ptr_next = r_wr_ptr + P_ONE;
      end
    end else begin
      w_wr_ptr_next = r_wr_ptr;
    end
    if (w_wr_acc && !w_rd_acc) begin
      w_count_next = r_count + C_ONE;
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_next = r_count - C_ONE;
    end else begin
      w_count_next = r_count;
    end
  end

  // Storage array; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers, count, flags from next count, error pulses and read register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_dout   <= {datawidth{1'b0}};
    end else begin
      r_rd_ptr <= w_rd_ptr_next;
      r_wr_ptr <= w_wr_ptr_next;
      r_count  <= w_count_next;
      r_full   <= (w_count_next == C_DEPTH);
      r_empty  <= (w_count_next == {CW{1'b0}});
      r_af     <= (w_count_next >= C_AF);
      r_ae     <= (w_count_next <= C_AE);
      r_ovf    <= wen && !w_wr_acc;
      r_udf    <= ren && !w_rd_acc;
      if (w_rd_acc) begin
        r_dout <= r_mem[r_rd_ptr];
      end
    end
  end

  // In FWFT mode r_dout keeps the last popped word, shown while empty.
  if (fwft) begin : g_fwft
    assign dout = r_empty ? r_dout : r_mem[r_rd_ptr];
  end else begin : g_std
    assign dout = r_dout;
  end

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Three FIFO builds (depth 8 std, depth 6 std, depth 8 FWFT) driven by shared
// stimulus and checked every cycle against a queue-based reference model.
module tb_sync_fifo_flags;

  typedef logic [7:0] q_t [$];

  logic clk = 1'b0;
  logic rst;
  logic wen;
  logic ren;
  logic [7:0] din;

  logic [7:0] act_dout [3];
  logic [3:0] act_cnt  [3];
  logic [5:0] act_flg  [3];
  logic [7:0] exp_dout [3];
  logic [3:0] exp_cnt  [3];
  logic [5:0] exp_flg  [3];

  q_t q0;
  q_t q1;
  q_t q2;
  logic [7:0] last0;
  logic [7:0] last1;
  logic [7:0] last2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int D  = (g == 1) ? 6 : 8;
    localparam int CW = $clog2(D + 1);
    localparam bit FW = (g == 2) ? 1'b1 : 1'b0;
    logic [7:0]    dout_s;
    logic [CW-1:0] cnt_s;
    logic full_s, empty_s, af_s, ae_s, ovf_s, udf_s;

    sync_fifo_flags #(
      .datawidth(8), .depth(D), .af_thresh(D - 2), .ae_thresh(2), .fwft(FW)
    ) u_dut (
      .clk(clk), .rst(rst), .wen(wen), .ren(ren), .din(din), .dout(dout_s),
      .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s),
      .count(cnt_s), .overflow(ovf_s), .underflow(udf_s)
    );

    assign act_dout[g] = dout_s;
    assign act_cnt[g]  = 4'(cnt_s);
    assign act_flg[g]  = {full_s, empty_s, af_s, ae_s, ovf_s, udf_s};
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, a, e);
    end
  endtask

  // Flag vector order: {full, empty, almost_full, almost_empty, overflow, underflow}
  task automatic model_step(input int i, inout q_t q, inout logic [7:0] last);
    int  d;
    int  n;
    logic rd_m;
    logic wr_m;
    d    = (i == 1) ? 6 : 8;
    rd_m = !rst && ren && (q.size() > 0);
    wr_m = !rst && wen && ((q.size() < d) || rd_m);
    if (rst) begin
      q.delete();
      last = 8'h00;
    end else begin
      if (rd_m) last = q.pop_front();
      if (wr_m) q.push_back(din);
    end
    n = q.size();
    exp_cnt[i]  = 4'(n);
    exp_dout[i] = (i == 2 && n > 0) ? q[0] : last;
    exp_flg[i]  = {n == d, n == 0, n >= d - 2, n <= 2,
                   !rst && wen && !wr_m, !rst && ren && !rd_m};
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dout[%0d]", i),  act_dout[i], exp_dout[i]);
      chk($sformatf("count[%0d]", i), act_cnt[i],  exp_cnt[i]);
      chk($sformatf("flags[%0d]", i), act_flg[i],  exp_flg[i]);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
    rst = r;
    wen = w;
    ren = rd;
    din = d;
    model_step(0, q0, last0);
    model_step(1, q1, last1);
    model_step(2, q2, last2);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [7:0] wd;
    logic       w;
    logic       r;
    last0 = 8'h00;
    last1 = 8'h00;
    last2 = 8'h00;

    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("reset_count", exp_cnt[0], 4'd0);
    chk("reset_flags", exp_flg[0], 6'b010100);
    chk("reset_dout",  exp_dout[0], 8'h00);

    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'(k * 17));
      if (k == 5) chk("af_low_at5", exp_flg[0][3], 1'b0);
      if (k == 6) chk("af_at6", exp_flg[0][3], 1'b1);
    end
    chk("full_at8",      exp_flg[0][5], 1'b1);
    chk("count_at8",     exp_cnt[0], 4'd8);
    chk("d6_count_cap",  exp_cnt[1], 4'd6);
    chk("d6_overflow",   exp_flg[1][1], 1'b1);

    step(1'b0, 1'b1, 1'b0, 8'h99);
    chk("ovf_pulse",     exp_flg[0][1], 1'b1);
    chk("ovf_count",     exp_cnt[0], 4'd8);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf_one_cycle", exp_flg[0][1], 1'b0);

    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      if (k == 1) chk("drain_first", exp_dout[0], 8'h11);
      if (k == 8) chk("drain_last", exp_dout[0], 8'h88);
      if (k == 8) chk("drain_empty", exp_flg[0][4], 1'b1);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("udf_pulse",  exp_flg[0][0], 1'b1);
    chk("udf_hold",   exp_dout[0], 8'h88);
    chk("d6_hold",    exp_dout[1], 8'h66);

    for (int k = 1; k <= 8; k++) step(1'b0, 1'b1, 1'b0, 8'(k * 17));
    step(1'b0, 1'b1, 1'b1, 8'hAA);
    chk("simul_count", exp_cnt[0], 4'd8);
    chk("simul_full",  exp_flg[0][5], 1'b1);
    chk("simul_novf",  exp_flg[0][1], 1'b0);
    chk("simul_dout",  exp_dout[0], 8'h11);
    for (int k = 1; k <= 8; k++) step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("simul_tail",  exp_dout[0], 8'hAA);

    step(1'b0, 1'b1, 1'b0, 8'h5A);
    chk("fwft_nonempty", exp_flg[2][4], 1'b0);
    chk("fwft_dout",     exp_dout[2], 8'h5A);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("fwft_count",    exp_cnt[2], 4'd0);
    chk("fwft_empty",    exp_flg[2][4], 1'b1);
    chk("fwft_hold",     exp_dout[2], 8'h5A);

    wd = 8'h11;
    for (int c = 0; c < 20; c++) begin
      w = ((c % 5) < 3);
      r = ((c % 5) >= 2);
      step(1'b0, w, r, wd);
      if (w) wd = wd + 8'h11;
      chk("wrap_count_le6", act_cnt[1] <= 4'd6, 1'b1);
    end

    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 50, 8'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised successor to the team's single-clock synchronous FIFO. It adds:
- an occupancy count output;
- programmable almost-full and almost-empty thresholds;
- overflow and underflow error pulses;
- a build-time choice between standard registered-read mode and first-word-fall-through (FWFT) mode.

It sits between a producer and a consumer in the same clock domain and is a drop-in replacement for the existing FIFO when FWFT=0.

Parameters:
- datawidth, 8, bit width of din/dout.
- depth, 8, number of entries; any integer >=2, not required to be a power of two.
- af_thresh, depth-2, almost_full asserts when count >= af_thresh; legal range 1..depth.
- ae_thresh, 2, almost_empty asserts when count <= ae_thresh; legal range 0..depth-1.
- fwft, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- wen  input  1  write request.
- ren  input  1  read request.
- din  input  datawidth  write data.
- dout  output  datawidth  read data.
- full  output  1  count == depth.
- empty  output  1  count == 0.
- almost_full  output  1  count >= af_thresh.
- almost_empty  output  1  count <= ae_thresh.
- count  output  $clog2(depth+1)  current occupancy.
- overflow  output  1  one-cycle pulse: write rejected in the previous cycle.
- underflow  output  1  one-cycle pulse: read rejected in the previous cycle.

Behaviour:
- Reset: rst=1 sampled at a clk edge clears rd_ptr, wr_ptr and count.
  - Output values after reset: dout=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0.
  - Memory contents are not cleared.
  - rst overrides wen/ren in the same cycle; no transfer occurs.
  - Reset mid-operation discards all stored data.
- Read acceptance: rd_acc = ren && !empty.
- Write acceptance: wr_acc = wen && (!full || rd_acc).
  - A write to a full FIFO is accepted only when a read is accepted in the same cycle.
- Simultaneous rd_acc and wr_acc: count unchanged; both pointers advance.
  - Holds at full: count stays depth and full stays 1.
  - At empty, rd_acc=0, so the write is accepted alone and count becomes 1.
- Pointer wrap: each pointer advances modulo depth (depth-1 -> 0). Non-power-of-two depth uses explicit compare-and-wrap.
- Count: count_next = count + wr_acc - rd_acc.
  - full, empty, almost_full and almost_empty are registered, derived from count_next, so they are valid the same cycle count updates.
- Overflow/underflow:
  - overflow=1 for exactly one cycle after an edge where wen=1 and wr_acc=0.
  - underflow=1 for exactly one cycle after an edge where ren=1 and rd_acc=0.
  - Neither pulse changes FIFO state.
- fwft=0 (standard mode):
  - On rd_acc, dout loads mem[rd_ptr] at that edge, so data is visible one cycle after ren is sampled.
  - dout holds its value when no read is accepted, including across underflow.
- fwft=1 (FWFT mode):
  - dout = mem[rd_ptr] combinationally whenever empty=0, so the head word is visible without a request and ren acts as pop/acknowledge.
  - When empty=1, dout holds its last value (0 after reset).
  - Write-to-dout latency from an empty FIFO: the word appears the cycle after the write edge, together with empty deasserting.
- Threshold flags may both be 1 simultaneously when the thresholds overlap; no priority applies.

Test Plan:
- Reset/idle: rst high for 4 cycles then low, no requests -> empty=1, almost_empty=1, count=0, dout=0, all other flags 0.
- Fill to full (depth=8, af_thresh=6, fwft=0): write 0x11,0x22,...,0x88 on 8 consecutive cycles.
  - almost_full rises when count=6.
  - full=1 at count=8.
  - A 9th write of 0x99 gives overflow=1 for one cycle and count stays 8.
- Drain and underflow: from full, ren for 8 cycles -> dout shows 0x11..0x88, each one cycle after its ren edge.
  - empty=1 after the 8th read.
  - A further ren gives underflow=1 for one cycle and dout holds 0x88.
- Simultaneous at full: with full=1, assert wen=ren=1 with din=0xAA.
  - Head word is read out; 0xAA is accepted.
  - count stays 8, full stays 1, overflow=0.
- Wrap-around (depth=6, non-power-of-two): 20 cycles of alternating write bursts and reads (the same pattern as the fill scenario, with din incrementing by 0x11) -> output order matches input order across pointer wrap; count never exceeds 6.
- FWFT mode (fwft=1): write 0x5A to an empty FIFO.
  - Next cycle: empty=0 and dout=0x5A with ren=0.
  - Then assert ren: count goes to 0, empty=1, and dout holds 0x5A.
